fetch_sequencer: RTL and testbench

//  Controls the IF stage of the 5-stage RV32I pipeline. Owns PCF and drives a

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_hold_buf.sv | 29 ++
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants used by the fetch stage.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned ILEN         = 32;

  // addi x0, x0, 0 -- the canonical bubble instruction
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer that parks a fetched {instr, pc} while decode is stalled.
module fetch_hold_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [31:0]     instrIn,
  input  logic [XLEN-1:0] pcIn,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);

  // Clear wins over load so a redirect can never leave a stale entry behind.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instrIn;
      pc    <= pcIn;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage controller: owns PCF, runs the single-outstanding imem port and
// loads the IF/ID register, honouring execute redirects and decode stalls.
module fetch_sequencer #(
  parameter int unsigned         XLEN     = riscv_pkg::XLEN_DEFAULT,
  parameter logic [XLEN-1:0]     RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  import riscv_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] PC_ALIGN = XLEN'(3);

  fetch_state_t    state, nextState;
  logic [XLEN-1:0] pcF, pcNext;
  logic [XLEN-1:0] reqPc, reqPcNext;
  logic            accept;
  logic            ifidLoad, ifidBubble, ifidFlush;
  logic [31:0]     ifidInstr;
  logic [XLEN-1:0] ifidPc;
  logic            holdLoad, holdClear, holdValid;
  logic [31:0]     holdInstr;
  logic [XLEN-1:0] holdPc;

  assign accept        = imem_req_valid & imem_req_ready;
  assign imem_req_addr = pcF;

  fetch_hold_buf #(.XLEN(XLEN)) uHoldBuf (
    .clk     (clk),
    .rst     (rst),
    .load    (holdLoad),
    .clear   (holdClear),
    .instrIn (imem_rsp_data),
    .pcIn    (reqPc),
    .valid   (holdValid),
    .instr   (holdInstr),
    .pc      (holdPc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= nextState;
  end

  // Next state, PC update, hold-buffer control and IF/ID load selection.
  always_comb begin
    nextState  = state;
    pcNext     = pcF;
    reqPcNext  = reqPc;
    ifidLoad   = 1'b0;
    ifidInstr  = imem_rsp_data;
    ifidPc     = reqPc;
    ifidFlush  = 1'b0;
    holdLoad   = 1'b0;
    holdClear  = 1'b0;

    unique case (state)
      REQ: begin
        if (accept) begin
          reqPcNext = pcF;
          pcNext    = pcF + PC_STEP;
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (!StallD) begin
            ifidLoad  = 1'b1;
            nextState = REQ;
          end else begin
            holdLoad  = 1'b1;
            nextState = HOLD;
          end
        end
      end
      HOLD: begin
        if (!StallD) begin
          ifidLoad  = 1'b1;
          ifidInstr = holdInstr;
          ifidPc    = holdPc;
          holdClear = 1'b1;
          nextState = REQ;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) nextState = REQ;
      end
    endcase

    // A redirect overrides everything; an in-flight request must still drain.
    if (PCSrcE) begin
      pcNext    = PCTargetE & ~PC_ALIGN;
      ifidFlush = 1'b1;
      ifidLoad  = 1'b0;
      holdLoad  = 1'b0;
      holdClear = 1'b1;
      unique case (state)
        REQ:   nextState = accept ? DRAIN : REQ;
        WAIT:  nextState = imem_rsp_valid ? REQ : DRAIN;
        HOLD:  nextState = REQ;
        DRAIN: nextState = imem_rsp_valid ? REQ : DRAIN;
      endcase
    end

    ifidBubble = !StallD && !ifidLoad;
  end

  // PC registers, request-valid register and the IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF            <= RESET_PC;
      reqPc          <= '0;
      imem_req_valid <= 1'b0;
      InstrD         <= NOP_INSTR;
      PCD            <= '0;
      PCPlus4D       <= '0;
      ValidD         <= 1'b0;
    end else begin
      pcF            <= pcNext;
      reqPc          <= reqPcNext;
      imem_req_valid <= (nextState == REQ);
      if (ifidFlush || ifidBubble) begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end else if (ifidLoad) begin
        InstrD   <= ifidInstr;
        PCD      <= ifidPc;
        PCPlus4D <= ifidPc + PC_STEP;
        ValidD   <= 1'b1;
      end
    end
  end

  // A response is only legal while a request is outstanding.
  rspOnlyWhenOutstanding: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (state == REQ || state == HOLD)));

  holdBufferFullInHold: assert property (@(posedge clk) disable iff (rst)
    (state == HOLD) |-> holdValid);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: table-driven cycle vectors, a
// variable-latency memory model and a delivery scoreboard.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        reqValid;
  logic [31:0] reqAddr;
  logic        ready;
  logic        rspValid;
  logic [31:0] rspData;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .StallD         (StallD),
    .imem_req_valid (reqValid),
    .imem_req_addr  (reqAddr),
    .imem_req_ready (ready),
    .imem_rsp_valid (rspValid),
    .imem_rsp_data  (rspData),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        stall;
    logic        expReqValid;
    logic [31:0] expReqAddr;
    logic        expValidD;
    logic [31:0] expPcd;
  } vec_t;

  exp_t        sbQ[$];
  int          tests = 0;
  int          fails = 0;
  int          deliveries = 0;
  int          memLat = 1;
  int          cnt = 0;
  bit          pending = 0;
  bit          dropNext = 0;
  logic [31:0] pendAddr = '0;
  int          expGap = -1;
  int          gap = 0;
  bit          gapValid = 0;
  logic        lastValid = 0;
  logic [31:0] lastPcd = '0;
  logic [31:0] lastInstr = '0;

  function automatic logic [31:0] instrOf(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0003;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: detect each newly delivered IF/ID entry and check it.
  task automatic observe();
    exp_t e;
    if (ValidD) begin
      if (!lastValid || PCD != lastPcd || InstrD != lastInstr) begin
        deliveries++;
        if (sbQ.size() == 0) begin
          check("unexpectedDelivery", PCD, 32'hDEAD_BEEF);
        end else begin
          e = sbQ.pop_front();
          check("deliverInstr", InstrD, e.instr);
          check("deliverPc", PCD, e.pc);
          check("deliverPcPlus4", PCPlus4D, e.pc + 32'd4);
        end
        if (expGap >= 0 && gapValid) check("bubbleCount", gap, expGap);
        gap = 0;
        gapValid = 1;
      end
    end else begin
      check("bubbleIsNop", InstrD, NOP);
      gap++;
    end
    lastValid = ValidD;
    lastPcd   = PCD;
    lastInstr = InstrD;
  endtask

  // Memory model: one outstanding request, response memLat cycles after handshake.
  task automatic memDrive();
    rspValid = 1'b0;
    if (rst) begin
      pending  = 0;
      dropNext = 0;
      return;
    end
    if (pending) begin
      if (cnt == 0) begin
        rspValid = 1'b1;
        rspData  = instrOf(pendAddr);
        pending  = 0;
        if (PCSrcE || dropNext) dropNext = 0;
        else sbQ.push_back('{instr: rspData, pc: pendAddr});
      end else begin
        cnt--;
      end
    end
    if (reqValid && ready) begin
      pending  = 1;
      pendAddr = reqAddr;
      cnt      = memLat - 1;
    end
    if (PCSrcE && pending) dropNext = 1;
  endtask

  task automatic atNeg();
    @(negedge clk);
    observe();
    memDrive();
  endtask

  task automatic toPos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    atNeg();
    toPos();
  endtask

  task automatic resetDut();
    rst = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sbQ.delete();
    gapValid  = 0;
    lastValid = 0;
    dropNext  = 0;
    expGap    = -1;
  endtask

  task automatic waitDelivery(input string name, input int maxTicks);
    int start;
    bit got;
    start = deliveries;
    got   = 0;
    for (int i = 0; i < maxTicks && !got; i++) begin
      tick();
      if (deliveries > start) got = 1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  vec_t t1[10];

  initial begin
    // Zero-wait memory: one delivery every two cycles, bubble in between.
    t1[0] = '{0, 0, 32'h00, 0, 32'h0};
    t1[1] = '{0, 1, 32'h00, 0, 32'h0};
    t1[2] = '{0, 0, 32'h04, 0, 32'h0};
    t1[3] = '{0, 1, 32'h04, 1, 32'h0};
    t1[4] = '{0, 0, 32'h08, 0, 32'h0};
    t1[5] = '{0, 1, 32'h08, 1, 32'h4};
    t1[6] = '{0, 0, 32'h0C, 0, 32'h4};
    t1[7] = '{0, 1, 32'h0C, 1, 32'h8};
    t1[8] = '{0, 0, 32'h10, 0, 32'h8};
    t1[9] = '{0, 1, 32'h10, 1, 32'hC};

    rspValid = 1'b0;
    rspData  = '0;

    // Test 1: reset state and zero-wait streaming.
    resetDut();
    memLat = 1;
    check("rstInstrD", InstrD, NOP);
    check("rstPCPlus4D", PCPlus4D, 32'h0);
    for (int i = 0; i < 10; i++) begin
      StallD = t1[i].stall;
      atNeg();
      check($sformatf("t1ReqValid[%0d]", i), 32'(reqValid), 32'(t1[i].expReqValid));
      check($sformatf("t1ReqAddr[%0d]", i), reqAddr, t1[i].expReqAddr);
      check($sformatf("t1ValidD[%0d]", i), 32'(ValidD), 32'(t1[i].expValidD));
      check($sformatf("t1Pcd[%0d]", i), PCD, t1[i].expPcd);
      toPos();
    end

    // Test 2: response three cycles after issue (counting the issue cycle) -> 2 bubbles.
    resetDut();
    memLat = 2;
    expGap = 2;
    begin
      int d0;
      d0 = deliveries;
      for (int i = 0; i < 14; i++) tick();
      check("t2Deliveries", 32'(deliveries - d0 >= 4), 32'd1);
    end
    expGap = -1;

    // Test 3: response for PC=8 arrives under a 3-cycle stall.
    resetDut();
    memLat = 1;
    for (int c = 0; c < 6; c++) tick();
    for (int c = 6; c <= 8; c++) begin
      StallD = 1'b1;
      atNeg();
      check($sformatf("t3NoReq[%0d]", c), 32'(reqValid), 32'd0);
      check($sformatf("t3HeldPcd[%0d]", c), PCD, 32'h4);
      check($sformatf("t3HeldValid[%0d]", c), 32'(ValidD), 32'd0);
      toPos();
    end
    StallD = 1'b0;
    atNeg();
    check("t3NoReqRelease", 32'(reqValid), 32'd0);
    check("t3HeldPcdRelease", PCD, 32'h4);
    toPos();
    atNeg();
    check("t3BufferedValid", 32'(ValidD), 32'd1);
    check("t3BufferedPcd", PCD, 32'h8);
    toPos();

    // Test 4: redirect in WAIT without response; target low bits forced to zero.
    resetDut();
    memLat = 2;
    tick();
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
    tick();
    PCSrcE = 1'b0;
    atNeg();
    check("t4DrainNoReq", 32'(reqValid), 32'd0);
    toPos();
    atNeg();
    check("t4ReqValid", 32'(reqValid), 32'd1);
    check("t4ReqAddr", reqAddr, 32'h100);
    check("t4StaleDropped", 32'(ValidD), 32'd0);
    toPos();
    waitDelivery("t4Delivered", 10);
    check("t4FirstPcd", PCD, 32'h100);

    // Test 5: redirect with a same-cycle response while decode is stalled.
    resetDut();
    memLat = 1;
    for (int c = 0; c < 3; c++) tick();
    StallD = 1'b1;
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
    atNeg();
    check("t5PreValid", 32'(ValidD), 32'd1);
    check("t5PrePcd", PCD, 32'h0);
    toPos();
    PCSrcE = 1'b0; StallD = 1'b0;
    atNeg();
    check("t5FlushValid", 32'(ValidD), 32'd0);
    check("t5FlushInstr", InstrD, NOP);
    check("t5ReqValid", 32'(reqValid), 32'd1);
    check("t5ReqAddr", reqAddr, 32'h200);
    toPos();
    waitDelivery("t5Delivered", 10);
    check("t5Pcd", PCD, 32'h200);

    // Test 6a: reset while a request is outstanding.
    resetDut();
    memLat = 2;
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sbQ.delete();
    lastValid = 0;
    gapValid  = 0;
    atNeg();
    check("t6ReqValid", 32'(reqValid), 32'd0);
    check("t6ReqAddr", reqAddr, 32'h0);
    check("t6ValidD", 32'(ValidD), 32'd0);
    check("t6InstrD", InstrD, NOP);
    check("t6Pcd", PCD, 32'h0);
    check("t6PcPlus4", PCPlus4D, 32'h0);
    toPos();
    waitDelivery("t6Refetch", 10);
    check("t6RefetchPcd", PCD, 32'h0);

    // Test 6b: PC wrap, also redirect in REQ without handshake.
    resetDut();
    memLat = 1;
    ready  = 1'b0;
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    atNeg();
    check("t7ReqIdle", reqAddr, 32'h0);
    toPos();
    PCSrcE = 1'b0; ready = 1'b1;
    atNeg();
    check("t7ReqValid", 32'(reqValid), 32'd1);
    check("t7ReqAddrTop", reqAddr, 32'hFFFF_FFFC);
    toPos();
    tick();
    atNeg();
    check("t7WrapPcd", PCD, 32'hFFFF_FFFC);
    check("t7WrapPcPlus4", PCPlus4D, 32'h0);
    check("t7WrapReqAddr", reqAddr, 32'h0);
    toPos();
    ready = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("sbEmpty", 32'(sbQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
